// File: rtl/e15_pkg.sv
// Shared constants for the e15 output tracker: state indices, output-code words
// and the successor tables used to follow the controller from its outputs.
package e15_pkg;

  localparam int NUM_STATES = 18;
  localparam int Y_W        = 20;
  localparam int ID_W       = 5;

  typedef logic [NUM_STATES-1:0] state_vec_t;

  // Zero-based state index: S1 is bit 0 of a state vector
  typedef enum logic [ID_W-1:0] {
    S1 = 5'd0,  S2 = 5'd1,  S3 = 5'd2,  S4 = 5'd3,  S5 = 5'd4,  S6 = 5'd5,
    S7 = 5'd6,  S8 = 5'd7,  S9 = 5'd8,  S10 = 5'd9, S11 = 5'd10, S12 = 5'd11,
    S13 = 5'd12, S14 = 5'd13, S15 = 5'd14, S16 = 5'd15, S17 = 5'd16, S18 = 5'd17
  } state_idx_t;

  // Output word of each state; bit i carries y(i+1)
  localparam logic [Y_W-1:0] C_S2  = 20'h08000;  // y16
  localparam logic [Y_W-1:0] C_S3  = 20'h40000;  // y19
  localparam logic [Y_W-1:0] C_S4  = 20'h00181;  // y1 y8 y9
  localparam logic [Y_W-1:0] C_S5  = 20'h00007;  // y1 y2 y3
  localparam logic [Y_W-1:0] C_S6  = 20'h00803;  // y1 y2 y12
  localparam logic [Y_W-1:0] C_S7  = 20'h00A02;  // y2 y10 y12
  localparam logic [Y_W-1:0] C_S8  = 20'h20000;  // y18
  localparam logic [Y_W-1:0] C_S9  = 20'h00E00;  // y10 y11 y12
  localparam logic [Y_W-1:0] C_S10 = 20'h04140;  // y7 y9 y15
  localparam logic [Y_W-1:0] C_S11 = 20'h00010;  // y5
  localparam logic [Y_W-1:0] C_S12 = 20'h00008;  // y4
  localparam logic [Y_W-1:0] C_S13 = 20'h10180;  // y8 y9 y17
  localparam logic [Y_W-1:0] C_S14 = 20'h00020;  // y6
  localparam logic [Y_W-1:0] C_S15 = 20'h00C01;  // y1 y11 y12
  localparam logic [Y_W-1:0] C_S16 = 20'h80000;  // y20
  localparam logic [Y_W-1:0] C_S17 = 20'h06101;  // y1 y9 y14 y15
  localparam logic [Y_W-1:0] C_S18 = 20'h01000;  // y13

  // Row k: legal nonzero-code successors of state k+1
  localparam state_vec_t SUCC_MASK [NUM_STATES] = '{
    18'h00FFE, 18'h01000, 18'h03C00, 18'h0C500, 18'h00C00, 18'h02008,
    18'h30000, 18'h08200, 18'h30C10, 18'h08002, 18'h0026C, 18'h1026C,
    18'h00080, 18'h01002, 18'h02000, 18'h00C02, 18'h11802, 18'h10802
  };

  // Row k: states reachable from state k+1 while the output word is all-zero
  localparam state_vec_t ZERO_MASK [NUM_STATES] = '{
    18'h00001, 18'h00003, 18'h00000, 18'h00009, 18'h00000, 18'h00021,
    18'h00040, 18'h00001, 18'h00100, 18'h00200, 18'h00001, 18'h00001,
    18'h01001, 18'h00001, 18'h04000, 18'h00000, 18'h10001, 18'h00000
  };

endpackage

// File: rtl/e15_output_tracker_if.sv
// Sample-in / tracking-result-out bundle between a word source and the tracker.
interface e15_output_tracker_if
  import e15_pkg::*;
#(
  parameter int CNT_W = 16
) ();
  logic             in_valid;
  logic [Y_W-1:0]   y_word;
  logic             clear_err;
  state_vec_t       state_set;
  logic [ID_W-1:0]  state_id;
  logic             locked;
  logic             err_code;
  logic             err_trans;
  logic             out_valid;
  logic [CNT_W-1:0] trans_cnt;

  modport master (
    output in_valid, y_word, clear_err,
    input  state_set, state_id, locked, err_code, err_trans, out_valid, trans_cnt
  );

  modport slave (
    input  in_valid, y_word, clear_err,
    output state_set, state_id, locked, err_code, err_trans, out_valid, trans_cnt
  );
endinterface

// File: rtl/e15_code_decoder.sv
// Maps a controller output word to the unique state that emits it, or flags
// the all-zero word / an unrecognised word.
module e15_code_decoder
  import e15_pkg::*;
(
  input  logic [Y_W-1:0] y_word,
  output state_idx_t     target,
  output logic           is_zero,
  output logic           is_unknown
);

  always_comb begin
    target     = S1;
    is_zero    = 1'b0;
    is_unknown = 1'b0;
    case (y_word)
      C_S2:    target = S2;
      C_S3:    target = S3;
      C_S4:    target = S4;
      C_S5:    target = S5;
      C_S6:    target = S6;
      C_S7:    target = S7;
      C_S8:    target = S8;
      C_S9:    target = S9;
      C_S10:   target = S10;
      C_S11:   target = S11;
      C_S12:   target = S12;
      C_S13:   target = S13;
      C_S14:   target = S14;
      C_S15:   target = S15;
      C_S16:   target = S16;
      C_S17:   target = S17;
      C_S18:   target = S18;
      '0:      is_zero = 1'b1;
      default: is_unknown = 1'b1;
    endcase
  end

endmodule

// File: rtl/e15_output_tracker.sv
// Follows the e15 controller from its output words alone, keeping the set of
// states it could currently be in plus sticky code/transition error flags.
module e15_output_tracker
  import e15_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic rst_n,
  e15_output_tracker_if.slave bus
);

  state_idx_t       tgt_p0;
  logic             zero_p0, unk_p0, legal_p0;
  state_vec_t       zero_next_p0, set_next_p0;
  logic             code_err_p0, trans_err_p0;
  logic [CNT_W-1:0] cnt_next_p0;

  state_vec_t       set_p1;
  logic             err_code_p1, err_trans_p1, vld_p1;
  logic [CNT_W-1:0] cnt_p1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [ID_W-1:0] onehot_id(input state_vec_t v);
    logic [ID_W-1:0] id;
    id = '0;
    for (int k = 0; k < NUM_STATES; k++)
      if (v == (state_vec_t'(1) << k)) id = ID_W'(k + 1);
    return id;
  endfunction

  e15_code_decoder u_dec (
    .y_word    (bus.y_word),
    .target    (tgt_p0),
    .is_zero   (zero_p0),
    .is_unknown(unk_p0)
  );

  // p0: legality of the decoded code against the current set, and next set
  always_comb begin
    legal_p0     = 1'b0;
    zero_next_p0 = '0;
    for (int k = 0; k < NUM_STATES; k++) begin
      if (set_p1[k]) begin
        legal_p0     = legal_p0 | SUCC_MASK[k][tgt_p0];
        zero_next_p0 = zero_next_p0 | ZERO_MASK[k];
      end
    end
  end

  always_comb begin
    set_next_p0  = set_p1;
    code_err_p0  = 1'b0;
    trans_err_p0 = 1'b0;
    cnt_next_p0  = cnt_p1;
    if (bus.in_valid) begin
      if (unk_p0) begin
        set_next_p0 = '1;
        code_err_p0 = 1'b1;
      end else if (zero_p0) begin
        // An empty ZERO image means we lost track: reopen every state
        if (zero_next_p0 == '0) begin
          set_next_p0  = '1;
          trans_err_p0 = 1'b1;
        end else begin
          set_next_p0 = zero_next_p0;
        end
      end else begin
        set_next_p0  = state_vec_t'(1) << tgt_p0;
        trans_err_p0 = ~legal_p0;
        cnt_next_p0  = sat_inc(cnt_p1);
      end
    end
  end

  // p1: registered tracking state; a new error outranks a same-cycle clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      set_p1       <= state_vec_t'(1);
      err_code_p1  <= 1'b0;
      err_trans_p1 <= 1'b0;
      vld_p1       <= 1'b0;
      cnt_p1       <= '0;
    end else begin
      set_p1       <= set_next_p0;
      err_code_p1  <= (err_code_p1 & ~bus.clear_err) | code_err_p0;
      err_trans_p1 <= (err_trans_p1 & ~bus.clear_err) | trans_err_p0;
      vld_p1       <= bus.in_valid;
      cnt_p1       <= cnt_next_p0;
    end
  end

  assign bus.state_set = set_p1;
  assign bus.state_id  = onehot_id(set_p1);
  assign bus.locked    = $onehot(set_p1);
  assign bus.err_code  = err_code_p1;
  assign bus.err_trans = err_trans_p1;
  assign bus.out_valid = vld_p1;
  assign bus.trans_cnt = cnt_p1;

endmodule

// File: tb/tb_e15_output_tracker.sv
// Directed-vector bench for e15_output_tracker with hand-computed expectations.
module tb_e15_output_tracker;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_pass = 0;
  int n_total = 0;

  e15_output_tracker_if #(.CNT_W(CW)) bus ();

  e15_output_tracker #(.CNT_W(CW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic step(input logic v, input logic [19:0] w, input logic clr);
    bus.in_valid = v; bus.y_word = w; bus.clear_err = clr;
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.y_word = '0; bus.clear_err = 1'b0;
  endtask

  task automatic do_reset();
    bus.in_valid = 1'b0; bus.y_word = '0; bus.clear_err = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0; bus.y_word = '0; bus.clear_err = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk); #1;
    n_total++; if (bus.state_set !== 18'h00001) $display("FAIL rst_set: got %0h expected %0h", bus.state_set, 18'h00001); else n_pass++;
    n_total++; if (bus.state_id !== 5'd1) $display("FAIL rst_id: got %0d expected %0d", bus.state_id, 1); else n_pass++;
    n_total++; if (bus.locked !== 1'b1) $display("FAIL rst_locked: got %0b expected 1", bus.locked); else n_pass++;
    n_total++; if ({bus.err_code, bus.err_trans, bus.out_valid} !== 3'b000) $display("FAIL rst_flags: got %03b expected 000", {bus.err_code, bus.err_trans, bus.out_valid}); else n_pass++;
    n_total++; if (bus.trans_cnt !== 4'd0) $display("FAIL rst_cnt: got %0d expected 0", bus.trans_cnt); else n_pass++;
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_first_code();
    do_reset();
    step(1'b1, 20'h08000, 1'b0);
    n_total++; if (bus.out_valid !== 1'b1) $display("FAIL y16_vld: got %0b expected 1", bus.out_valid); else n_pass++;
    n_total++; if (bus.state_id !== 5'd2) $display("FAIL y16_id: got %0d expected 2", bus.state_id); else n_pass++;
    n_total++; if (bus.locked !== 1'b1) $display("FAIL y16_locked: got %0b expected 1", bus.locked); else n_pass++;
    n_total++; if (bus.trans_cnt !== 4'd1) $display("FAIL y16_cnt: got %0d expected 1", bus.trans_cnt); else n_pass++;
    n_total++; if ({bus.err_code, bus.err_trans} !== 2'b00) $display("FAIL y16_err: got %02b expected 00", {bus.err_code, bus.err_trans}); else n_pass++;
    step(1'b0, 20'h00000, 1'b0);
    n_total++; if (bus.out_valid !== 1'b0) $display("FAIL idle_vld: got %0b expected 0", bus.out_valid); else n_pass++;
  endtask

  task automatic test_chain();
    do_reset();
    step(1'b1, 20'h08000, 1'b0);
    step(1'b1, 20'h10180, 1'b0);
    n_total++; if (bus.state_id !== 5'd13) $display("FAIL chain_s13: got %0d expected 13", bus.state_id); else n_pass++;
    step(1'b1, 20'h20000, 1'b0);
    n_total++; if (bus.state_id !== 5'd8) $display("FAIL chain_s8: got %0d expected 8", bus.state_id); else n_pass++;
    step(1'b1, 20'h04140, 1'b0);
    n_total++; if (bus.state_id !== 5'd10) $display("FAIL chain_s10: got %0d expected 10", bus.state_id); else n_pass++;
    // y16 plus three chain codes
    n_total++; if (bus.trans_cnt !== 4'd4) $display("FAIL chain_cnt: got %0d expected 4", bus.trans_cnt); else n_pass++;
    n_total++; if (bus.err_trans !== 1'b0) $display("FAIL chain_err: got %0b expected 0", bus.err_trans); else n_pass++;
  endtask

  task automatic test_zero();
    do_reset();
    step(1'b1, 20'h08000, 1'b0);
    step(1'b1, 20'h00000, 1'b0);
    n_total++; if (bus.state_set !== 18'h00003) $display("FAIL zero_set: got %0h expected 3", bus.state_set); else n_pass++;
    n_total++; if ({bus.locked, bus.state_id} !== 6'd0) $display("FAIL zero_unlock: got %0b/%0d expected 0/0", bus.locked, bus.state_id); else n_pass++;
    n_total++; if (bus.trans_cnt !== 4'd1) $display("FAIL zero_cnt: got %0d expected 1", bus.trans_cnt); else n_pass++;
    step(1'b1, 20'h40000, 1'b0);
    n_total++; if (bus.state_id !== 5'd3) $display("FAIL zero_y19_id: got %0d expected 3", bus.state_id); else n_pass++;
    n_total++; if (bus.err_trans !== 1'b0) $display("FAIL zero_y19_err: got %0b expected 0", bus.err_trans); else n_pass++;
    // s3 has no ZERO successor
    step(1'b1, 20'h00000, 1'b0);
    n_total++; if (bus.state_set !== 18'h3FFFF) $display("FAIL empty_set: got %0h expected 3ffff", bus.state_set); else n_pass++;
    n_total++; if (bus.err_trans !== 1'b1) $display("FAIL empty_err: got %0b expected 1", bus.err_trans); else n_pass++;
  endtask

  task automatic test_illegal();
    do_reset();
    step(1'b1, 20'h01000, 1'b0);
    n_total++; if (bus.err_trans !== 1'b1) $display("FAIL ill_err: got %0b expected 1", bus.err_trans); else n_pass++;
    n_total++; if (bus.state_id !== 5'd18) $display("FAIL ill_id: got %0d expected 18", bus.state_id); else n_pass++;
    n_total++; if (bus.trans_cnt !== 4'd1) $display("FAIL ill_cnt: got %0d expected 1", bus.trans_cnt); else n_pass++;
    step(1'b0, 20'h00000, 1'b1);
    n_total++; if (bus.err_trans !== 1'b0) $display("FAIL clr_err: got %0b expected 0", bus.err_trans); else n_pass++;
    // s18 -> s18 is illegal; the new error beats the clear
    step(1'b1, 20'h01000, 1'b1);
    n_total++; if (bus.err_trans !== 1'b1) $display("FAIL setwins_err: got %0b expected 1", bus.err_trans); else n_pass++;
    n_total++; if (bus.err_code !== 1'b0) $display("FAIL ill_code: got %0b expected 0", bus.err_code); else n_pass++;
    step(1'b0, 20'h00010, 1'b0);
    n_total++; if ({bus.out_valid, bus.state_id, bus.trans_cnt, bus.err_trans} !== {1'b0, 5'd18, 4'd2, 1'b1}) $display("FAIL hold: got %0b/%0d/%0d/%0b expected 0/18/2/1", bus.out_valid, bus.state_id, bus.trans_cnt, bus.err_trans); else n_pass++;
  endtask

  task automatic test_unknown();
    do_reset();
    step(1'b1, 20'h08000, 1'b0);
    step(1'b1, 20'h00003, 1'b0);
    n_total++; if (bus.err_code !== 1'b1) $display("FAIL unk_code: got %0b expected 1", bus.err_code); else n_pass++;
    n_total++; if (bus.state_set !== 18'h3FFFF) $display("FAIL unk_set: got %0h expected 3ffff", bus.state_set); else n_pass++;
    n_total++; if (bus.trans_cnt !== 4'd1) $display("FAIL unk_cnt: got %0d expected 1", bus.trans_cnt); else n_pass++;
    n_total++; if ({bus.locked, bus.state_id} !== 6'd0) $display("FAIL unk_unlock: got %0b/%0d expected 0/0", bus.locked, bus.state_id); else n_pass++;
    // s7 is in the open set and lists s18 as a successor
    step(1'b1, 20'h01000, 1'b0);
    n_total++; if ({bus.state_id, bus.err_trans} !== {5'd18, 1'b0}) $display("FAIL relock: got %0d/%0b expected 18/0", bus.state_id, bus.err_trans); else n_pass++;
    step(1'b0, 20'h00000, 1'b1);
    n_total++; if (bus.err_code !== 1'b0) $display("FAIL unk_clr: got %0b expected 0", bus.err_code); else n_pass++;
  endtask

  task automatic test_saturate();
    do_reset();
    for (int i = 0; i < 15; i++) step(1'b1, 20'h08000, 1'b0);
    n_total++; if (bus.trans_cnt !== 4'd15) $display("FAIL sat_top: got %0d expected 15", bus.trans_cnt); else n_pass++;
    step(1'b1, 20'h08000, 1'b0);
    n_total++; if (bus.trans_cnt !== 4'd15) $display("FAIL sat_hold: got %0d expected 15", bus.trans_cnt); else n_pass++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    @(negedge clk);
    bus.in_valid = 1'b1; bus.y_word = 20'h00010;
    #2 rst_n = 1'b0;
    @(posedge clk); #1;
    n_total++; if ({bus.state_id, bus.trans_cnt, bus.out_valid} !== {5'd1, 4'd0, 1'b0}) $display("FAIL midrst: got %0d/%0d/%0b expected 1/0/0", bus.state_id, bus.trans_cnt, bus.out_valid); else n_pass++;
    bus.in_valid = 1'b0; bus.y_word = '0;
    @(negedge clk); rst_n = 1'b1;
    step(1'b1, 20'h00010, 1'b0);
    n_total++; if ({bus.state_id, bus.trans_cnt, bus.out_valid} !== {5'd11, 4'd1, 1'b1}) $display("FAIL post_rst: got %0d/%0d/%0b expected 11/1/1", bus.state_id, bus.trans_cnt, bus.out_valid); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_first_code();
    test_chain();
    test_zero();
    test_illegal();
    test_unknown();
    test_saturate();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
